// File: rtl/psum_col_reducer_if.sv
// Column-side and result-side handshake bundle for one PE-row partial-sum reducer.
// The slave modport is the reducer; the master modport is the surrounding column FIFOs plus the consumer.
interface psum_col_reducer_if #(
  parameter int NUM_COL   = 4,
  parameter int LANES     = 18,
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 16
);
  logic [NUM_COL-1:0]                     col_valid;
  logic [NUM_COL-1:0]                     col_ready;
  logic [NUM_COL-1:0][LANES*IN_WIDTH-1:0] col_data;
  logic [NUM_COL-1:0]                     gate_col;
  logic [NUM_COL-1:0]                     done_col;
  logic                                   out_valid;
  logic                                   out_ready;
  logic [LANES*OUT_WIDTH-1:0]             out_data;
  logic [LANES-1:0]                       out_sat;
  logic [15:0]                            beat_cnt;
  logic                                   busy;

  modport slave (
    input  col_valid, col_data, gate_col, done_col, out_ready,
    output col_ready, out_valid, out_data, out_sat, beat_cnt, busy
  );

  modport master (
    output col_valid, col_data, gate_col, done_col, out_ready,
    input  col_ready, out_valid, out_data, out_sat, beat_cnt, busy
  );
endinterface

// File: rtl/psum_col_reducer.sv
// Lock-step pop of all participating PE columns, lane-wise signed sum (stage 1),
// then clamp/wrap to the output width (stage 2), presented with valid/ready backpressure.
module psum_col_reducer #(
  parameter int PSUM_WIDTH = 16,
  parameter int NUM_COL    = 4,
  parameter int LANES      = 18,
  parameter int IN_WIDTH   = PSUM_WIDTH,
  parameter int OUT_WIDTH  = PSUM_WIDTH,
  parameter bit SATURATE   = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  psum_col_reducer_if.slave   bus
);

  localparam int ACC_W = IN_WIDTH + $clog2(NUM_COL);
  // One guard bit above the wider of sum and output keeps the range compare exact either way.
  localparam int CMP_W = ((ACC_W > OUT_WIDTH) ? ACC_W : OUT_WIDTH) + 1;
  localparam logic signed [CMP_W-1:0] MAX_V = {{(CMP_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [CMP_W-1:0] MIN_V = {{(CMP_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  logic [NUM_COL-1:0] part;
  logic               any_part, all_valid, s2_free, s1_can_load, accept, s1_move, xfer;

  logic                          s1_valid_q, s1_valid_d;
  logic [LANES-1:0][ACC_W-1:0]   s1_sum_q, s1_sum_d;
  logic                          s2_valid_q, s2_valid_d;
  logic [LANES*OUT_WIDTH-1:0]    s2_data_q, s2_data_d;
  logic [LANES-1:0]              s2_sat_q, s2_sat_d;
  logic [15:0]                   beat_cnt_q, beat_cnt_d;

  // Handshake: a beat needs every participating column ready at once and room in stage 1.
  assign part        = ~bus.gate_col & ~bus.done_col;
  assign any_part    = |part;
  assign all_valid   = &(bus.col_valid | ~part);
  assign xfer        = s2_valid_q & bus.out_ready;
  assign s2_free     = ~s2_valid_q | bus.out_ready;
  assign s1_move     = s1_valid_q & s2_free;
  assign s1_can_load = ~s1_valid_q | s2_free;
  assign accept      = ~rst & any_part & all_valid & s1_can_load;

  assign s1_valid_d  = accept | (s1_valid_q & ~s2_free);
  assign s2_valid_d  = s2_free ? s1_valid_q : s2_valid_q;
  assign beat_cnt_d  = beat_cnt_q + {15'd0, xfer};

  always_comb begin
    // NOTE: defaulting every output of a combinational block before any branch is what
    // keeps synthesis from inferring latches; the loop below also relies on blocking '='
    // so each partial sum is visible to the next iteration within the same evaluation.
    s1_sum_d = '0;
    for (int k = 0; k < LANES; k++) begin
      for (int j = 0; j < NUM_COL; j++) begin
        if (part[j]) begin
          s1_sum_d[k] = s1_sum_d[k] + ACC_W'($signed(bus.col_data[j][k*IN_WIDTH +: IN_WIDTH]));
        end
      end
    end
  end

  always_comb begin
    logic signed [CMP_W-1:0] wide;
    wide      = '0;
    s2_data_d = '0;
    s2_sat_d  = '0;
    for (int k = 0; k < LANES; k++) begin
      wide = {{(CMP_W-ACC_W){s1_sum_q[k][ACC_W-1]}}, s1_sum_q[k]};
      if (wide > MAX_V) begin
        s2_sat_d[k]                        = 1'b1;
        s2_data_d[k*OUT_WIDTH +: OUT_WIDTH] = SATURATE ? MAX_V[OUT_WIDTH-1:0] : wide[OUT_WIDTH-1:0];
      end else if (wide < MIN_V) begin
        s2_sat_d[k]                        = 1'b1;
        s2_data_d[k*OUT_WIDTH +: OUT_WIDTH] = SATURATE ? MIN_V[OUT_WIDTH-1:0] : wide[OUT_WIDTH-1:0];
      end else begin
        s2_data_d[k*OUT_WIDTH +: OUT_WIDTH] = wide[OUT_WIDTH-1:0];
      end
    end
  end

  // NOTE: the stage-1 sum is only ever read while s1_valid_q is set, so it carries no
  // reset; control and visible outputs are reset, and state uses '<=' so all registers
  // sample the same pre-edge values.
  always_ff @(posedge clk) begin
    if (accept) s1_sum_q <= s1_sum_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_sat_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      beat_cnt_q <= beat_cnt_d;
      if (s1_move) begin
        s2_data_q <= s2_data_d;
        s2_sat_q  <= s2_sat_d;
      end
    end
  end

  assign bus.col_ready = {NUM_COL{accept}} & part;
  assign bus.out_valid = s2_valid_q;
  assign bus.out_data  = s2_data_q;
  assign bus.out_sat   = s2_sat_q;
  assign bus.beat_cnt  = beat_cnt_q;
  assign bus.busy      = s1_valid_q | s2_valid_q;

endmodule

// File: tb/tb_psum_col_reducer.sv
// Bench for psum_col_reducer: a saturating and a wrapping instance share one stimulus stream
// and are compared every cycle against a queue-based model of the two-slot result pipeline.
module tb_psum_col_reducer;
  localparam int NC = 4;
  localparam int LN = 18;
  localparam int W  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NC-1:0]          col_valid = '0;
  logic [NC-1:0]          gate      = '0;
  logic [NC-1:0]          done      = '0;
  logic                   out_ready = 1'b1;
  logic [NC-1:0][LN*W-1:0] col_data = '0;

  psum_col_reducer_if #(.NUM_COL(NC), .LANES(LN), .IN_WIDTH(W), .OUT_WIDTH(W)) bus_s ();
  psum_col_reducer_if #(.NUM_COL(NC), .LANES(LN), .IN_WIDTH(W), .OUT_WIDTH(W)) bus_w ();

  assign bus_s.col_valid = col_valid;
  assign bus_s.col_data  = col_data;
  assign bus_s.gate_col  = gate;
  assign bus_s.done_col  = done;
  assign bus_s.out_ready = out_ready;
  assign bus_w.col_valid = col_valid;
  assign bus_w.col_data  = col_data;
  assign bus_w.gate_col  = gate;
  assign bus_w.done_col  = done;
  assign bus_w.out_ready = out_ready;

  psum_col_reducer #(.PSUM_WIDTH(W), .NUM_COL(NC), .LANES(LN), .SATURATE(1'b1))
    dut_s (.clk(clk), .rst(rst), .bus(bus_s));
  psum_col_reducer #(.PSUM_WIDTH(W), .NUM_COL(NC), .LANES(LN), .SATURATE(1'b0))
    dut_w (.clk(clk), .rst(rst), .bus(bus_w));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [LN-1:0][31:0] sum;
    int                  acc_cyc;
  } beat_t;

  beat_t q[$];
  int    cyc_n     = 0;
  int    exp_cnt   = 0;
  bit    presented = 1'b0;

  function automatic logic [LN-1:0][31:0] beat_sum(input logic [NC-1:0] p,
                                                   input logic [NC-1:0][LN*W-1:0] d);
    logic [LN-1:0][31:0] r;
    r = '0;
    for (int k = 0; k < LN; k++) begin
      int s;
      s = 0;
      for (int j = 0; j < NC; j++) if (p[j]) s += $signed(d[j][k*W +: W]);
      r[k] = s;
    end
    return r;
  endfunction

  function automatic logic [LN*W-1:0] conv_data(input logic [LN-1:0][31:0] s, input bit sat);
    logic [LN*W-1:0] r;
    r = '0;
    for (int k = 0; k < LN; k++) begin
      int v;
      v = s[k];
      if (sat && v > 32767)  v = 32767;
      if (sat && v < -32768) v = -32768;
      r[k*W +: W] = v[15:0];
    end
    return r;
  endfunction

  function automatic logic [LN-1:0] conv_flags(input logic [LN-1:0][31:0] s);
    logic [LN-1:0] r;
    r = '0;
    for (int k = 0; k < LN; k++) begin
      int v;
      v = s[k];
      r[k] = (v > 32767) || (v < -32768);
    end
    return r;
  endfunction

  always @(negedge clk) begin : model
    logic [NC-1:0] part, exp_ready;
    bit            exp_valid, can_load, acc;
    beat_t         b;
    part      = ~gate & ~done;
    exp_valid = (q.size() > 0) && (q[0].acc_cyc <= cyc_n - 2);
    can_load  = (q.size() < 2) || (exp_valid && out_ready);
    acc       = !rst && (|part) && (&(col_valid | ~part)) && can_load;
    exp_ready = acc ? part : '0;

    check("col_ready_sat",  bus_s.col_ready, exp_ready);
    check("col_ready_wrap", bus_w.col_ready, exp_ready);
    check("out_valid_sat",  bus_s.out_valid, exp_valid);
    check("out_valid_wrap", bus_w.out_valid, exp_valid);
    check("busy_sat",       bus_s.busy, q.size() > 0);
    check("busy_wrap",      bus_w.busy, q.size() > 0);
    check("beat_cnt",       bus_s.beat_cnt, exp_cnt[15:0]);
    if (exp_valid) begin
      check("out_data_sat",  bus_s.out_data, conv_data(q[0].sum, 1'b1));
      check("out_data_wrap", bus_w.out_data, conv_data(q[0].sum, 1'b0));
      check("out_sat_sat",   bus_s.out_sat, conv_flags(q[0].sum));
      check("out_sat_wrap",  bus_w.out_sat, conv_flags(q[0].sum));
    end else if (!presented) begin
      check("out_data_rst", bus_s.out_data, '0);
      check("out_sat_rst",  bus_s.out_sat, '0);
    end

    if (rst) begin
      q.delete();
      exp_cnt   = 0;
      presented = 1'b0;
    end else begin
      if (exp_valid) presented = 1'b1;
      if (exp_valid && out_ready) begin
        void'(q.pop_front());
        exp_cnt++;
      end
      if (acc) begin
        b.sum     = beat_sum(part, col_data);
        b.acc_cyc = cyc_n;
        q.push_back(b);
      end
    end
    cyc_n++;
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    col_valid = '0;
    gate      = '0;
    done      = '0;
  endtask

  task automatic rand_data();
    for (int j = 0; j < NC; j++) begin
      for (int k = 0; k < LN; k++) begin
        int unsigned r;
        r = $urandom_range(0, 7);
        col_data[j][k*W +: W] = (r == 0) ? 16'h7FFF : (r == 1) ? 16'h8000 : 16'($urandom);
      end
    end
  endtask

  initial begin
    logic [LN-1:0][31:0] pin;
    int sent, xfers;

    rst = 1'b1;
    repeat (3) cyc();
    rst = 1'b0;

    // Mixed-sign lane 0: 100 - 50 + 7 + 1 = 58.
    col_data = '0;
    col_data[0][15:0] = 16'd100;
    col_data[1][15:0] = 16'hFFCE;
    col_data[2][15:0] = 16'd7;
    col_data[3][15:0] = 16'd1;
    col_valid = 4'hF;
    pin = beat_sum(4'hF, col_data);
    check("model_pin_58", pin[0], 32'd58);
    @(negedge clk);
    check("t1_col_ready", bus_s.col_ready, 4'hF);
    cyc(); idle();
    cyc();
    @(negedge clk);
    check("t1_out_valid", bus_s.out_valid, 1'b1);
    check("t1_lane0",     bus_s.out_data[15:0], 16'd58);
    check("t1_out_sat",   bus_s.out_sat, '0);
    cyc();
    @(negedge clk);
    check("t1_beat_cnt",  bus_s.beat_cnt, 16'd1);

    // Gated column 2 is neither waited on nor popped.
    cyc();
    gate = 4'b0100;
    col_valid = 4'b1011;
    for (int j = 0; j < NC; j++) for (int k = 0; k < LN; k++) col_data[j][k*W +: W] = 16'd10;
    @(negedge clk);
    check("t2_col_ready", bus_s.col_ready, 4'b1011);
    cyc(); idle();
    cyc();
    @(negedge clk);
    check("t2_lane0",  bus_s.out_data[15:0], 16'd30);
    check("t2_lane17", bus_s.out_data[17*W +: W], 16'd30);

    // Positive overflow in lane 5: clamp vs wrap.
    cyc();
    col_data = '0;
    for (int j = 0; j < NC; j++) col_data[j][5*W +: W] = 16'h7FFF;
    col_valid = 4'hF;
    cyc(); idle();
    cyc();
    @(negedge clk);
    check("t3_sat_lane5",   bus_s.out_data[5*W +: W], 16'h7FFF);
    check("t3_sat_flag5",   bus_s.out_sat[5], 1'b1);
    check("t3_wrap_lane5",  bus_w.out_data[5*W +: W], 16'hFFFC);
    check("t3_wrap_flag5",  bus_w.out_sat[5], 1'b1);
    cyc();

    // All columns done: nothing accepted even with every FIFO non-empty.
    cyc();
    done = 4'hF;
    col_valid = 4'hF;
    repeat (4) begin
      @(negedge clk);
      check("t4_col_ready", bus_s.col_ready, '0);
      check("t4_out_valid", bus_s.out_valid, 1'b0);
      check("t4_busy",      bus_s.busy, 1'b0);
      cyc();
    end
    idle();

    // Eight-beat stream with a four-cycle downstream stall.
    sent  = 0;
    xfers = 0;
    for (int i = 0; i < 20; i++) begin
      out_ready = !(i >= 3 && i <= 6);
      col_valid = (sent < 8) ? 4'hF : 4'h0;
      rand_data();
      @(negedge clk);
      if (bus_s.col_ready != '0) sent++;
      if (bus_s.out_valid && out_ready) xfers++;
      cyc();
    end
    check("t5_beats_sent", sent, 8);
    check("t5_results",    xfers, 8);
    idle();
    out_ready = 1'b1;

    // Reset with two beats in flight, then a fresh beat.
    out_ready = 1'b0;
    col_valid = 4'hF;
    rand_data();
    cyc();
    rand_data();
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    out_ready = 1'b1;
    rand_data();
    @(negedge clk);
    check("t6_out_valid", bus_s.out_valid, 1'b0);
    check("t6_busy",      bus_s.busy, 1'b0);
    check("t6_beat_cnt",  bus_s.beat_cnt, 16'd0);
    cyc(); idle();
    cyc();
    @(negedge clk);
    check("t6_latency", bus_s.out_valid, 1'b1);
    cyc();

    // Randomised traffic with occasional gating, done columns and resets.
    repeat (2000) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int j = 0; j < NC; j++) begin
        col_valid[j] = ($urandom_range(0, 7) != 0);
        gate[j]      = ($urandom_range(0, 7) == 0);
        done[j]      = ($urandom_range(0, 9) == 0);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      rand_data();
      cyc();
    end
    rst = 1'b0;
    idle();
    out_ready = 1'b1;
    repeat (5) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
